// File: rtl/clksk_pkg.sv
// Shared types and defaults for the PLL reset/lock sequencer.
package clksk_pkg;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  localparam int unsigned RST_HOLD_CYC_D = 8;
  localparam int unsigned LOCK_TIMEOUT_D = 2000;
  localparam int unsigned LOCK_STABLE_D  = 64;
  localparam int unsigned RETRY_W        = 8;

endpackage

// File: rtl/clksk_sync2.sv
// Generic two-flop synchronizer for a single asynchronous status bit.
module clksk_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset/lock sequencer: pulses PLL reset, waits for stable lock, then releases sys_rst.
module pll_rst_seq
  import clksk_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYC = RST_HOLD_CYC_D,
  parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_D,
  parameter int unsigned LOCK_STABLE  = LOCK_STABLE_D,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               soft_req,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               timeout_err,
  output logic               lock_lost
);

  localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TmoLast    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] StableLast = CNT_W'(LOCK_STABLE - 1);

  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_rst_q, sys_rst_d;
  logic               ready_q, ready_d;
  logic               tmo_q, tmo_d;
  logic               lost_q, lost_d;
  logic               retry_inc, set_tmo, set_lost;
  logic               lock_s;

  clksk_sync2 u_lock_sync (
    .clk_i (clk_in),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      tmo_q     <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      tmo_q     <= tmo_d;
      lost_q    <= lost_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    retry_inc = 1'b0;
    set_tmo   = 1'b0;
    set_lost  = 1'b0;
    unique case (state_q)
      RESET_PLL: begin
        if (cnt_q == HoldLast) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock seen on the timeout cycle wins over the retry.
        if (lock_s) begin
          state_d = STABLE;
        end else if (cnt_q == TmoLast) begin
          state_d   = RESET_PLL;
          set_tmo   = 1'b1;
          retry_inc = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == StableLast) begin
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q;
        if (!lock_s) begin
          state_d   = RESET_PLL;
          set_lost  = 1'b1;
          retry_inc = 1'b1;
        end else if (soft_req) begin
          state_d = RESET_PLL;
        end
      end
      default: state_d = RESET_PLL;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are decoded from the next state so they register on the same edge.
  always_comb begin
    pll_rst_d = (state_d == RESET_PLL);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
    tmo_d     = tmo_q | set_tmo;
    lost_d    = lost_q | set_lost;
    retry_d   = retry_q;
    if (retry_inc && (retry_q != '1)) retry_d = retry_q + 1'b1;
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign retry_cnt   = retry_q;
  assign timeout_err = tmo_q;
  assign lock_lost   = lost_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Scoreboard bench for pll_rst_seq plus a short-timing instance for retry saturation.
module tb_pll_rst_seq;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       soft_req = 1'b0;
  logic       pll_rst, sys_rst, ready, timeout_err, lock_lost;
  logic [7:0] retry_cnt;

  logic       rst2 = 1'b1;
  logic       pll_rst2, sys_rst2, ready2, timeout_err2, lock_lost2;
  logic [7:0] retry_cnt2;

  int n_checks = 0;
  int n_pass = 0;

  logic [12:0] exp_q[$];

  // Reference model state
  int   m_st, m_cnt, m_retry;
  logic m_s1, m_s2, m_terr, m_llost;

  always #5 clk_in = ~clk_in;

  pll_rst_seq u_dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .soft_req    (soft_req),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .retry_cnt   (retry_cnt),
    .timeout_err (timeout_err),
    .lock_lost   (lock_lost)
  );

  pll_rst_seq #(
    .RST_HOLD_CYC (3),
    .LOCK_TIMEOUT (4),
    .LOCK_STABLE  (4),
    .CNT_W        (16)
  ) u_dut_sat (
    .clk_in      (clk_in),
    .rst         (rst2),
    .pll_locked  (1'b0),
    .soft_req    (1'b0),
    .pll_rst     (pll_rst2),
    .sys_rst     (sys_rst2),
    .ready       (ready2),
    .retry_cnt   (retry_cnt2),
    .timeout_err (timeout_err2),
    .lock_lost   (lock_lost2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_retry = 0;
    m_s1 = 1'b0; m_s2 = 1'b0; m_terr = 1'b0; m_llost = 1'b0;
  endtask

  task automatic model_retry();
    if (m_retry < 255) m_retry++;
  endtask

  task automatic model_edge(input logic lk, input logic sr);
    logic ls;
    ls = m_s2;
    m_s2 = m_s1;
    m_s1 = lk;
    case (m_st)
      0: if (m_cnt == 7) begin m_st = 1; m_cnt = 0; end else m_cnt++;
      1: begin
        if (ls) begin m_st = 2; m_cnt = 0; end
        else if (m_cnt == 1999) begin m_st = 0; m_cnt = 0; m_terr = 1'b1; model_retry(); end
        else m_cnt++;
      end
      2: begin
        if (!ls) begin m_st = 1; m_cnt = 0; end
        else if (m_cnt == 63) begin m_st = 3; m_cnt = 0; end
        else m_cnt++;
      end
      default: begin
        if (!ls) begin m_st = 0; m_cnt = 0; m_llost = 1'b1; model_retry(); end
        else if (sr) begin m_st = 0; m_cnt = 0; end
      end
    endcase
  endtask

  // Drive one cycle of inputs, advance the model on the edge and queue the expected outputs.
  task automatic step(input logic lk, input logic sr);
    logic [7:0] r;
    pll_locked = lk;
    soft_req = sr;
    @(posedge clk_in);
    if (rst) model_reset();
    else model_edge(lk, sr);
    r = 8'(m_retry);
    exp_q.push_back({m_st == 0, m_st != 3, m_st == 3, r, m_terr, m_llost});
    #1;
  endtask

  always @(negedge clk_in) begin
    logic [12:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("scoreboard", {19'd0, pll_rst, sys_rst, ready, retry_cnt, timeout_err, lock_lost},
               {19'd0, e});
    end
  end

  task automatic apply_rst();
    @(negedge clk_in);
    #2 rst = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // Hold lock high until sys_rst drops; returns edges taken (bounded).
  task automatic wait_run(output int n);
    n = 0;
    while (sys_rst && n < 300) begin
      step(1'b1, 1'b0);
      n++;
    end
  endtask

  initial begin
    int n;
    model_reset();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_eq("rst_pll_rst", pll_rst, 1);
    check_eq("rst_sys_rst", sys_rst, 1);
    check_eq("rst_ready", ready, 0);
    check_eq("rst_retry", retry_cnt, 0);
    check_eq("rst_tmo", timeout_err, 0);
    check_eq("rst_lost", lock_lost, 0);
    rst = 1'b0;

    // Never locks: three full timeout periods
    for (int e = 1; e <= 3 * 2008; e++) begin
      step(1'b0, 1'b0);
      if ((e % 2008) < 9 || (e % 2008) > 2005)
        check_eq("nolock_pll_rst", pll_rst, ((e % 2008) < 8) ? 1 : 0);
    end
    check_eq("nolock_retry", retry_cnt, 3);
    check_eq("nolock_tmo", timeout_err, 1);
    check_eq("nolock_sys_rst", sys_rst, 1);
    check_eq("nolock_lost", lock_lost, 0);

    // Lock after 100 cycles
    apply_rst();
    for (int e = 1; e <= 100; e++) begin
      step(1'b0, 1'b0);
      if (e == 7 || e == 8) check_eq("hold_pll_rst", pll_rst, (e == 7) ? 1 : 0);
    end
    wait_run(n);
    check_eq("lock_latency", n, 67);
    check_eq("lock_ready", ready, 1);
    check_eq("lock_retry", retry_cnt, 0);

    // Software re-lock from RUN, then soft_req in WAIT_LOCK is ignored
    step(1'b1, 1'b1);
    check_eq("soft_pll_rst", pll_rst, 1);
    check_eq("soft_sys_rst", sys_rst, 1);
    check_eq("soft_retry", retry_cnt, 0);
    check_eq("soft_lost", lock_lost, 0);
    repeat (8) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check_eq("soft_wait_ignored", pll_rst, 0);
    wait_run(n);
    check_eq("soft_relock", n, 67);

    // Lock glitch during STABLE restarts the stable count
    step(1'b1, 1'b1);
    repeat (9 + 30) step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    check_eq("glitch_sys_rst", sys_rst, 1);
    wait_run(n);
    check_eq("glitch_latency", n, 67);
    check_eq("glitch_retry", retry_cnt, 0);

    // Lock loss in RUN
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_eq("loss_still_run", ready, 1);
    step(1'b0, 1'b0);
    check_eq("loss_pll_rst", pll_rst, 1);
    check_eq("loss_sys_rst", sys_rst, 1);
    check_eq("loss_ready", ready, 0);
    check_eq("loss_flag", lock_lost, 1);
    check_eq("loss_retry", retry_cnt, 1);
    wait_run(n);
    check_eq("loss_relock", n, 73);

    // Async reset while in STABLE
    step(1'b1, 1'b1);
    repeat (19) step(1'b1, 1'b0);
    @(negedge clk_in);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_pll_rst", pll_rst, 1);
    check_eq("arst_sys_rst", sys_rst, 1);
    check_eq("arst_ready", ready, 0);
    check_eq("arst_retry", retry_cnt, 0);
    check_eq("arst_lost", lock_lost, 0);
    check_eq("arst_tmo", timeout_err, 0);
    step(1'b0, 1'b0);

    // Retry saturation on the short-timing instance
    @(posedge clk_in);
    #1 rst2 = 1'b0;
    repeat (7 * 254 + 3) @(posedge clk_in);
    #1 check_eq("sat_254", retry_cnt2, 254);
    repeat (4) @(posedge clk_in);
    #1 check_eq("sat_255", retry_cnt2, 255);
    repeat (21) @(posedge clk_in);
    #1 check_eq("sat_hold", retry_cnt2, 255);
    check_eq("sat_tmo", timeout_err2, 1);

    @(negedge clk_in);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
